// File: rtl/aes_sched_pkg.sv
// Shared types and the round-robin pick helper for the AES request scheduler.
package aes_sched_pkg;

    localparam int AES_BLK_W = 128;
    localparam int MAX_REQ   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2,
        RESP = 2'd3
    } state_t;

    // First set bit of valid[0..n-1] searching upward from (last+1) mod n, with wrap.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [2:0]         last,
                                           input int                 n);
        logic [2:0] idx;
        logic       found;
        rr_pick = '0;
        found   = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = 3'((int'(last) + k) % n);
            if (k <= n && !found && valid[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/aes_rr_arb.sv
// Combinational round-robin picker; the grant is only meaningful while some valid is set.
module aes_rr_arb
    import aes_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int GW   = 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [GW-1:0]   last_grant,
    output logic [NREQ-1:0] gnt_onehot,
    output logic [GW-1:0]   gnt_idx
);

    logic [MAX_REQ-1:0] valid_ext;
    logic [2:0]         pick;

    always_comb begin
        valid_ext             = '0;
        valid_ext[NREQ-1:0]   = valid;
        pick                  = rr_pick(valid_ext, 3'(last_grant), NREQ);
        gnt_idx               = GW'(pick);
        gnt_onehot            = (|valid) ? (NREQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/aes_req_sched.sv
// Shares one AES-128 encrypt core between NREQ requesters: round-robin grant,
// load pulse, wait for done (with watchdog), then a per-requester response.
module aes_req_sched
    import aes_sched_pkg::*;
#(
    parameter int  NREQ    = 2,
    parameter int  TIMEOUT = 511,
    localparam int GW      = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*AES_BLK_W-1:0] req_key,
    input  logic [NREQ*AES_BLK_W-1:0] req_text,
    output logic [NREQ-1:0]           rsp_valid,
    input  logic [NREQ-1:0]           rsp_ready,
    output logic [AES_BLK_W-1:0]      rsp_data,
    output logic                      rsp_err,
    output logic                      aes_ld,
    output logic [AES_BLK_W-1:0]      aes_key,
    output logic [AES_BLK_W-1:0]      aes_text,
    input  logic                      aes_done,
    input  logic [AES_BLK_W-1:0]      aes_text_out,
    output logic                      busy,
    output logic [GW-1:0]             grant_id
);

    state_t          state, state_nxt;
    logic [GW-1:0]   last_grant;
    logic [TW-1:0]   timer;
    logic [NREQ-1:0] gnt_onehot;
    logic [GW-1:0]   gnt_idx;
    logic            rsp_hs;
    logic            timed_out;

    aes_rr_arb #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_arb (
        .valid      (req_valid),
        .last_grant (last_grant),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx)
    );

    assign rsp_hs    = |(rsp_valid & rsp_ready);
    assign timed_out = (timer == TW'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        aes_ld    = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                req_ready = gnt_onehot;
                if (|req_valid) state_nxt = LOAD;
            end
            LOAD: begin
                aes_ld    = 1'b1;
                state_nxt = BUSY;
            end
            BUSY: begin
                if (aes_done || timed_out) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = NREQ'(1) << grant_id;
                if (rsp_hs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant capture, watchdog and response registers; done takes priority over timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= '0;
            grant_id   <= '0;
            timer      <= '0;
            aes_key    <= '0;
            aes_text   <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        aes_key  <= req_key[int'(gnt_idx)*AES_BLK_W +: AES_BLK_W];
                        aes_text <= req_text[int'(gnt_idx)*AES_BLK_W +: AES_BLK_W];
                        grant_id <= gnt_idx;
                    end
                end
                LOAD: timer <= '0;
                BUSY: begin
                    timer <= timer + TW'(1);
                    if (aes_done) begin
                        rsp_data <= aes_text_out;
                        rsp_err  <= 1'b0;
                    end else if (timed_out) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_hs) last_grant <= grant_id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_req_sched.sv
// Directed bench for aes_req_sched with a table-driven stand-in for the AES core.
module tb_aes_req_sched;

    localparam int NREQ     = 2;
    localparam int TIMEOUT  = 15;
    localparam int CORE_LAT = 8;

    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C2 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] P3 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C3 = 128'hf5d3d58503b9699de785895a96fdbaaf;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*128-1:0] req_key  = '0;
    logic [NREQ*128-1:0] req_text = '0;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready = '0;
    logic [127:0]       rsp_data;
    logic               rsp_err;
    logic               aes_ld;
    logic [127:0]       aes_key;
    logic [127:0]       aes_text;
    logic               aes_done;
    logic [127:0]       aes_text_out;
    logic               busy;
    logic [0:0]         grant_id;

    int vectors     = 0;
    int miscompares = 0;
    int gcnt[NREQ];

    always #5 clk = ~clk;

    aes_req_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_key      (req_key),
        .req_text     (req_text),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .aes_ld       (aes_ld),
        .aes_key      (aes_key),
        .aes_text     (aes_text),
        .aes_done     (aes_done),
        .aes_text_out (aes_text_out),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    // Stand-in core: known-answer table, fixed latency, optional hang.
    logic         core_hang = 1'b0;
    logic         core_busy;
    int           core_cnt;
    logic [127:0] core_key, core_pt;

    function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] p);
        if (k == K0 && p == P0) return C0;
        if (k == K1 && p == P1) return C1;
        if (k == K1 && p == P2) return C2;
        if (k == K1 && p == P3) return C3;
        return 128'h0bad;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_busy    <= 1'b0;
            core_cnt     <= 0;
            aes_done     <= 1'b0;
            aes_text_out <= '0;
            core_key     <= '0;
            core_pt      <= '0;
        end else begin
            aes_done <= 1'b0;
            if (aes_ld) begin
                core_busy <= 1'b1;
                core_cnt  <= 0;
                core_key  <= aes_key;
                core_pt   <= aes_text;
            end else if (core_busy) begin
                core_cnt <= core_cnt + 1;
                if (core_cnt == CORE_LAT - 1 && !core_hang) begin
                    aes_done     <= 1'b1;
                    aes_text_out <= aes_model(core_key, core_pt);
                    core_busy    <= 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NREQ; i++)
            if (req_valid[i] && req_ready[i]) gcnt[i] <= gcnt[i] + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string tag, input int idx, output int cyc);
        cyc = 0;
        while (rsp_valid[idx] !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk(tag, 128'(rsp_valid[idx]), 128'd1);
    endtask

    task automatic wait_any(input string tag, output int cyc);
        cyc = 0;
        while (rsp_valid === '0 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk(tag, 128'(|rsp_valid), 128'd1);
    endtask

    initial begin
        int cyc, g0, g1, bad, e;

        // Reset values
        #3;
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_req_ready", 128'(req_ready), 128'd0);
        chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("rst_aes_ld", 128'(aes_ld), 128'd0);
        chk("rst_aes_key", aes_key, 128'd0);
        chk("rst_rsp_data", rsp_data, 128'd0);
        chk("rst_rsp_err", 128'(rsp_err), 128'd0);
        chk("rst_grant_id", 128'(grant_id), 128'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // FIPS-197 C.1 on requester 0
        req_key[127:0]  = K0;
        req_text[127:0] = P0;
        req_valid       = 2'b01;
        #1;
        chk("c1_req_ready", 128'(req_ready), 128'b01);
        tick();
        chk("c1_ld", 128'(aes_ld), 128'd1);
        chk("c1_grant", 128'(grant_id), 128'd0);
        chk("c1_aes_key", aes_key, K0);
        chk("c1_aes_text", aes_text, P0);
        chk("c1_ready_load", 128'(req_ready), 128'd0);
        req_valid = '0;
        tick();
        chk("c1_ld_one_cycle", 128'(aes_ld), 128'd0);
        chk("c1_busy", 128'(busy), 128'd1);
        wait_rsp("c1_rsp_seen", 0, cyc);
        chk("c1_latency", 128'(cyc), 128'(CORE_LAT + 1));
        chk("c1_rsp_valid", 128'(rsp_valid), 128'b01);
        chk("c1_rsp_data", rsp_data, C0);
        chk("c1_rsp_err", 128'(rsp_err), 128'd0);
        chk("c1_key_hold", aes_key, K0);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = '0;
        chk("c1_idle", 128'(busy), 128'd0);
        chk("c1_rsp_drop", 128'(rsp_valid), 128'd0);

        // Backpressure on requester 0 while requester 1 waits
        req_key[127:0]    = K1;
        req_text[127:0]   = P1;
        req_key[255:128]  = K1;
        req_text[255:128] = P2;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b10;
        tick();
        wait_rsp("bp_rsp_seen", 0, cyc);
        rsp_ready = 2'b10;
        for (int i = 0; i < 20; i++) begin
            chk("bp_rsp_valid", 128'(rsp_valid), 128'b01);
            chk("bp_rsp_data", rsp_data, C1);
            chk("bp_req_ready", 128'(req_ready), 128'd0);
            tick();
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = '0;
        chk("bp_regrant_ready", 128'(req_ready), 128'b10);
        tick();
        chk("bp_regrant_id", 128'(grant_id), 128'd1);
        chk("bp_regrant_ld", 128'(aes_ld), 128'd1);
        chk("bp_regrant_text", aes_text, P2);
        req_valid = '0;
        wait_rsp("bp2_rsp_seen", 1, cyc);
        chk("bp2_rsp_data", rsp_data, C2);
        rsp_ready = 2'b10;
        tick();
        rsp_ready = '0;

        // Requester 1 alone, three back-to-back transactions
        req_text[255:128] = P3;
        req_valid = 2'b10;
        rsp_ready = 2'b11;
        g0 = gcnt[0];
        g1 = gcnt[1];
        for (int t = 0; t < 3; t++) begin
            wait_rsp("solo_rsp_seen", 1, cyc);
            chk("solo_grant", 128'(grant_id), 128'd1);
            chk("solo_rsp_valid", 128'(rsp_valid), 128'b10);
            chk("solo_rsp_data", rsp_data, C3);
            tick();
        end
        req_valid = '0;
        rsp_ready = '0;
        chk("solo_gnt1_count", 128'(gcnt[1] - g1), 128'd3);
        chk("solo_gnt0_count", 128'(gcnt[0] - g0), 128'd0);

        // Fairness with both requesters continuously valid
        req_key[127:0]    = K0;
        req_text[127:0]   = P0;
        req_key[255:128]  = K1;
        req_text[255:128] = P1;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int t = 0; t < 4; t++) begin
            e = t % 2;
            wait_any("rr_rsp_seen", cyc);
            chk("rr_grant", 128'(grant_id), 128'(e));
            chk("rr_rsp_valid", 128'(rsp_valid), 128'(1 << e));
            chk("rr_rsp_data", rsp_data, (e == 0) ? C0 : C1);
            tick();
        end
        req_valid = '0;
        rsp_ready = '0;

        // Watchdog with a hung core
        core_hang = 1'b1;
        req_valid = 2'b01;
        #1;
        chk("to_req_ready", 128'(req_ready), 128'b01);
        tick();
        req_valid = '0;
        chk("to_ld", 128'(aes_ld), 128'd1);
        tick();
        wait_rsp("to_rsp_seen", 0, cyc);
        chk("to_latency", 128'(cyc), 128'(TIMEOUT + 1));
        chk("to_rsp_err", 128'(rsp_err), 128'd1);
        chk("to_rsp_data", rsp_data, 128'd0);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = '0;
        core_hang = 1'b0;
        req_key[127:0]  = K1;
        req_text[127:0] = P1;
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        wait_rsp("after_to_rsp_seen", 0, cyc);
        chk("after_to_err", 128'(rsp_err), 128'd0);
        chk("after_to_data", rsp_data, C1);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = '0;

        // Asynchronous reset in the middle of BUSY
        core_hang = 1'b1;
        req_valid = 2'b10;
        tick();
        req_valid = '0;
        chk("mr_grant", 128'(grant_id), 128'd1);
        tick();
        repeat (10) tick();
        chk("mr_busy_before", 128'(busy), 128'd1);
        #2 rst = 1'b1;
        #1;
        chk("mr_busy", 128'(busy), 128'd0);
        chk("mr_grant_id", 128'(grant_id), 128'd0);
        chk("mr_aes_key", aes_key, 128'd0);
        chk("mr_aes_text", aes_text, 128'd0);
        chk("mr_rsp_data", rsp_data, 128'd0);
        chk("mr_rsp_err", 128'(rsp_err), 128'd0);
        chk("mr_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("mr_aes_ld", 128'(aes_ld), 128'd0);
        repeat (2) tick();
        rst       = 1'b0;
        core_hang = 1'b0;
        bad = 0;
        repeat (20) begin
            tick();
            if (rsp_valid !== '0) bad++;
        end
        chk("mr_no_stale_rsp", 128'(bad), 128'd0);
        req_key[127:0]  = K0;
        req_text[127:0] = P0;
        req_valid = 2'b01;
        #1;
        chk("mr_next_ready", 128'(req_ready), 128'b01);
        tick();
        req_valid = '0;
        chk("mr_next_grant", 128'(grant_id), 128'd0);
        chk("mr_next_key", aes_key, K0);
        wait_rsp("mr_next_rsp_seen", 0, cyc);
        chk("mr_next_data", rsp_data, C0);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aes_req_sched.md
Name: aes_req_sched

Overview:
- Shares one aes_cipher_top (AES-128 encrypt) instance between NREQ independent requesters.
- Arbitrates requests round-robin and latches the selected key and plaintext.
- Sequences the core: one-cycle load pulse, wait for done.
- Returns the ciphertext to the granted requester over a valid/ready response channel. A watchdog guards against a hung core.

Parameters:
- NREQ, 2, number of requesters (2..8).
- TIMEOUT, 511, max cycles in BUSY before an error response; counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester request accept (one-hot or zero)
- req_key  in  NREQ*128  packed keys; requester i at [i*128 +: 128]
- req_text  in  NREQ*128  packed plaintexts, same packing
- rsp_valid  out  NREQ  per-requester response valid (one-hot or zero)
- rsp_ready  in  NREQ  per-requester response accept
- rsp_data  out  128  ciphertext, shared by all requesters
- rsp_err  out  1  response is a timeout error; rsp_data = 0 when set
- aes_ld  out  1  load pulse to the core
- aes_key  out  128  key to the core
- aes_text  out  128  plaintext to the core
- aes_done  in  1  core completion pulse; core text_out is valid in the same cycle
- aes_text_out  in  128  core ciphertext
- busy  out  1  high in any state other than IDLE
- grant_id  out  clog2(NREQ)  index of the current or last granted requester

Behaviour:
- Reset values: state=IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, aes_ld=0, aes_key=0, aes_text=0, busy=0, grant_id=0, timer=0, rr pointer=0.
- FSM states: IDLE, LOAD, BUSY, RESP.
- IDLE:
  - If any req_valid, pick winner g: first valid index searching upward from (last_grant+1) mod NREQ, with wrap.
  - req_ready[g]=1 combinationally in the same cycle; transfer completes there.
  - On that edge: aes_key<=req_key[g], aes_text<=req_text[g], grant_id<=g, go to LOAD.
  - No req_valid: stay in IDLE, all req_ready=0.
- LOAD:
  - aes_ld=1 for exactly this one cycle; aes_key and aes_text stay stable.
  - Next: BUSY, timer<=0.
- BUSY:
  - aes_ld=0; timer increments each cycle.
  - On aes_done: rsp_data<=aes_text_out, rsp_err<=0, go to RESP.
  - Else if timer==TIMEOUT: rsp_data<=0, rsp_err<=1, go to RESP.
  - aes_done and timeout in the same cycle: aes_done wins.
- RESP:
  - rsp_valid[grant_id]=1; rsp_data and rsp_err held stable until handshake.
  - On rsp_ready[grant_id]: last_grant<=grant_id, go to IDLE.
  - rsp_ready on other indices is ignored.
- aes_key and aes_text hold their values after LOAD until the next grant.
- aes_done outside BUSY is ignored, with no state change.
- Only one transaction is in flight; req_ready stays 0 in LOAD, BUSY and RESP.
- Latency:
  - Grant edge to aes_ld: 1 cycle.
  - aes_done to rsp_valid: 1 cycle.
  - Response handshake to the next possible grant: 1 cycle (IDLE).
- Reset mid-operation: async return to reset values. Any pending response is dropped.
- rst also resets the core; rst is wired to the core's rstn via an inverter outside this block.

Decomposition:
- Package aes_sched_pkg:
  - state enum (IDLE, LOAD, BUSY, RESP), 2 bits.
  - AES_BLK_W=128.
  - function rr_pick(valid, last) returning the winning index.
- One sub-module: aes_rr_arb, the combinational round-robin picker. Inputs are valid[NREQ] and last_grant; outputs are gnt_onehot and gnt_idx.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff on requester 0 (real core).
  - Expect rsp_valid[0] with rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err=0.
  - Expect aes_ld high for exactly 1 cycle, 1 cycle after the grant.
- Round-robin fairness: both requesters valid continuously for 4 transactions with rsp_ready tied high.
  - Expect grant_id sequence 0,1,0,1; each requester gets correct ciphertext for its own key/text.
- Response backpressure: hold rsp_ready[0]=0 for 20 cycles after rsp_valid[0] rises.
  - Expect rsp_valid and rsp_data stable, req_ready=0 throughout.
  - Expect new grant 1 cycle after the rsp_ready pulse.
- Timeout: stub core never asserts aes_done, TIMEOUT=15.
  - Expect RESP entered 16 cycles after BUSY entry, rsp_err=1, rsp_data=0.
  - Then a later request with a working core returns rsp_err=0.
- Reset mid-BUSY: assert rst 30 cycles into BUSY.
  - Expect all outputs at reset values asynchronously and no rsp_valid after release.
  - Next request: grant goes to requester 0.
- Single requester 1 only, 3 back-to-back requests: expect grant_id=1 each time, no grants to idle requester 0.
